// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port used by the fetch stage.
// One word-read request/response channel: the fetch unit (master) raises
// IMemReq with IMemAddr, the memory (slave) accepts with IMemReady and later
// returns the word with a single-cycle IMemValid pulse.
interface instruction_fetch_unit_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic        IMemValid;
    logic [31:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemReady,
        input  IMemValid,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemReady,
        output IMemValid,
        output IMemData
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage.
// Owns the program counter, keeps at most one word read in flight to
// instruction memory, and buffers returned words in a 2-entry FIFO whose head
// feeds the IF/ID register as {PC+4, instruction}. Decode can stall the head
// or redirect the PC; a read that is in flight when a redirect arrives is
// drained and discarded (SQUASH) so wrong-path words never reach the FIFO.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       Clk,
    input  logic                       Rst,
    instruction_fetch_unit_if.master   imem,
    input  logic                       Stall,
    input  logic                       Redirect,
    input  logic [31:0]                RedirectPC,
    output logic [31:0]                PCAdder_out,
    output logic [31:0]                Instruction_out,
    output logic                       FetchValid
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,  // may present a request when the FIFO has room
        S_WAIT   = 2'd1,  // one read outstanding, data goes into the FIFO
        S_SQUASH = 2'd2   // one read outstanding, data is wrong-path
    } state_t;

    // Low alignment bits are masked rather than trusted.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_run;        // first edge after reset release enables issue
    logic [31:0] r_pc;         // next address to fetch
    logic [31:0] r_req_pc;     // address of the read in flight
    logic [1:0]  r_count;      // FIFO occupancy, 0..2
    logic [31:0] r_q_pc4   [2];  // entry 0 is always the head
    logic [31:0] r_q_instr [2];

    logic        w_req;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_push_pc4;

    // A request is offered only from REQ with a free FIFO slot, which
    // guarantees the eventual push in WAIT always finds room. It depends on
    // registered state only, never on IMemReady.
    assign w_req         = r_run && (r_state == S_REQ) && (r_count != 2'd2);
    assign w_accept      = w_req && imem.IMemReady;

    // Redirect cancels any same-cycle push or pop; the FIFO is flushed instead.
    assign w_push        = (r_state == S_WAIT) && imem.IMemValid && !Redirect;
    assign w_pop         = (r_count != 2'd0) && !Stall && !Redirect;

    assign w_redirect_pc = RedirectPC & ~32'h3;
    assign w_push_pc4    = r_req_pc + 32'd4;   // wraps modulo 2^32

    assign imem.IMemReq  = w_req;
    assign imem.IMemAddr = r_pc;

    // Head is presented straight from the FIFO register; empty reads as a NOP.
    assign FetchValid      = (r_count != 2'd0);
    assign PCAdder_out     = FetchValid ? r_q_pc4[0]   : 32'h0;
    assign Instruction_out = FetchValid ? r_q_instr[0] : 32'h0;

    // Next-state selection for the request/response sequencer.
    always_comb begin
        // NOTE: assigning the default before the case means every path drives
        // w_state_nxt, so no latch can be inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (Redirect) begin
                    // A request accepted this same edge is already binding:
                    // its data must be drained before fetching the new path.
                    w_state_nxt = w_accept ? S_SQUASH : S_REQ;
                end else if (w_accept) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Redirect) begin
                    // If the response arrives on the redirect edge it is
                    // simply dropped; nothing is left outstanding.
                    w_state_nxt = imem.IMemValid ? S_REQ : S_SQUASH;
                end else if (imem.IMemValid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_SQUASH: begin
                // A further redirect changes only the PC; the pending read
                // still has to be drained before a new one may be issued.
                if (imem.IMemValid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // Sequencer state, PC, in-flight address and FIFO occupancy.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state  <= S_REQ;
            r_run    <= 1'b0;
            r_pc     <= RESET_PC_ALIGNED;
            r_req_pc <= RESET_PC_ALIGNED;
            r_count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, independent of statement order.
            r_state <= w_state_nxt;
            r_run   <= 1'b1;

            if (Redirect) begin
                r_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_accept) begin
                r_req_pc <= r_pc;
            end

            if (Redirect) begin
                r_count <= 2'd0;
            end else begin
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO payload: shift toward the head on pop, write at the tail on push.
    // NOTE: the payload has no reset; r_count qualifies it and the outputs
    // are forced to zero while the FIFO is empty.
    always_ff @(posedge Clk) begin
        if (w_push && !w_pop) begin
            if (r_count == 2'd0) begin
                r_q_pc4[0]   <= w_push_pc4;
                r_q_instr[0] <= imem.IMemData;
            end else begin
                r_q_pc4[1]   <= w_push_pc4;
                r_q_instr[1] <= imem.IMemData;
            end
        end else if (!w_push && w_pop) begin
            r_q_pc4[0]   <= r_q_pc4[1];
            r_q_instr[0] <= r_q_instr[1];
        end else if (w_push && w_pop) begin
            if (r_count == 2'd1) begin
                r_q_pc4[0]   <= w_push_pc4;
                r_q_instr[0] <= imem.IMemData;
            end else begin
                r_q_pc4[0]   <= r_q_pc4[1];
                r_q_instr[0] <= r_q_instr[1];
                r_q_pc4[1]   <= w_push_pc4;
                r_q_instr[1] <= imem.IMemData;
            end
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the five-stage pipeline. It owns the program counter, issues word reads to instruction memory over a request/response handshake, and buffers returned instructions in a 2-entry queue. The queue feeds the IF/ID register with the {PC+4, instruction} pair and a valid flag. Stall and branch/jump redirect from decode are honoured, and wrong-path fetches are squashed.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset. Bits [1:0] must be 0.
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  asynchronous, active-low reset.
- Stall  in  1  IF/ID holding; the head entry must not be consumed.
- Redirect  in  1  taken branch/jump this cycle.
- RedirectPC  in  32  target PC; bits [1:0] are forced to 0 internally.
- IMemReq  out  1  read request valid.
- IMemAddr  out  32  word-aligned read address.
- IMemReady  in  1  memory accepts request this cycle when IMemReq=1.
- IMemValid  in  1  read data returned this cycle.
- IMemData  in  32  returned instruction word.
- PCAdder_out  out  32  PC+4 of head entry; 0 when empty.
- Instruction_out  out  32  head instruction; 0 (NOP) when empty.
- FetchValid  out  1  head entry present.

## Operation
- State: PC (32b), reqPC (32b, address of in-flight read), 2-entry queue of {PC+4, instr}, count (0..2), FSM.
- FSM states:
  - REQ: IMemReq=1 iff count<2, with IMemAddr=PC. On IMemReq&IMemReady: reqPC<=PC, PC<=PC+4, go to WAIT.
  - WAIT: IMemReq=0. On IMemValid: push {reqPC+4, IMemData}, go to REQ.
  - SQUASH: IMemReq=0. On IMemValid: discard data, go to REQ.
- At most one read outstanding. A read is issued only when count<2, so a push in WAIT always has a free slot.
- Pop occurs when FetchValid=1 and Stall=0. Push and pop in the same cycle leave count unchanged and preserve FIFO order.
- Redirect has priority over every other event. On Redirect:
  - Flush the queue (count<=0) and set PC<=RedirectPC&~3.
  - From WAIT, or from REQ with a request accepted that same cycle, go to SQUASH.
  - Otherwise go to REQ.
  - A same-cycle push or pop is cancelled.
- Redirect in REQ without IMemReady: IMemAddr changes to the new PC next cycle. An unaccepted request is non-binding.
- IMemValid is ignored in REQ.
- Arithmetic: PC+4 wraps modulo 2^32. 0xFFFF_FFFC advances to 0x0000_0000.
- Stall does not block issue. Fetch continues until the queue is full.

## Timing
- Reset (Rst=0, asynchronous): PC=RESET_PC, count=0, FSM=REQ, IMemReq=0, IMemAddr=RESET_PC, FetchValid=0, PCAdder_out=0, Instruction_out=0.
- First posedge after Rst deasserts: IMemReq=1.
- IMemReq and IMemAddr are combinational from registered state. They do not depend on IMemReady in the same cycle.
- Outputs are driven from the queue head register. A push at edge N makes FetchValid=1 after edge N when the queue was empty.
- With zero-wait memory (ready in REQ, valid the next cycle), peak throughput is 1 instruction per 2 cycles.
- First-fetch latency with zero-wait memory: FetchValid rises 2 edges after IMemReq first asserts.
- Reset mid-operation: immediately returns to the reset state. A late IMemValid after reset lands in REQ and is ignored.

## Test plan
- Reset/straight-line: RESET_PC=0x100, zero-wait memory returning addr^0xAAAA0000, Stall=0. Required response:
  - Addresses issued: 0x100, 0x104, 0x108, ...
  - Outputs delivered in order: (0x104, 0xAAAA0100), (0x108, 0xAAAA0104), ...
- Stall/backpressure: hold Stall=1 from the first valid output. Required response:
  - After 2 reads, count=2 and IMemReq=0.
  - The head stays at (0x104, …).
  - Release Stall: both entries pop over 2 cycles, then fetch resumes at 0x108.
- Redirect during WAIT: memory latency 3. Assert Redirect with RedirectPC=0x2003 while a read is outstanding. Required response:
  - The returning data is discarded and FetchValid stays 0.
  - The next IMemAddr is 0x2000.
  - The first output is (0x2004, …).
- Simultaneous events: with count=1, drive Redirect, IMemValid and a pop in the same cycle. Required response: count=0, the response is dropped, and the FSM is in REQ with PC=RedirectPC.
- Wrap: RESET_PC=0xFFFFFFFC. Required response: the first output has PCAdder_out=0x00000000, and the next IMemAddr is 0x00000000.
- Async reset mid-WAIT: pull Rst low between edges. Required response:
  - All outputs go to their reset values before the next edge.
  - An IMemValid pulse after reset release produces no push.
